// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_event_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 line synchronizers, 11-bit frame FSM and mid-frame timeout.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic         clk_meta_r, clk_sync_r, clk_prev_r;
  logic         data_meta_r, data_sync_r;
  frame_state_e state_r, state_s;
  logic [2:0]   bit_cnt_r, bit_cnt_s;
  logic [7:0]   shift_r, shift_s;
  logic         par_ok_r, par_ok_s;
  logic [TW-1:0] to_cnt_r, to_cnt_s;
  logic [7:0]   byte_r, byte_s;
  logic         byte_valid_r, byte_valid_s;
  logic         frame_err_r, frame_err_s;
  logic         fall_s, timeout_s, sampled_par_ok_s;

  assign fall_s = clk_prev_r & ~clk_sync_r;

`ifdef PS2_PARITY_CHECK_EN
  assign sampled_par_ok_s = odd_parity_ok(shift_r, data_sync_r);
`else
  assign sampled_par_ok_s = 1'b1;
`endif

  // Next-state and datapath updates for the frame receiver.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    par_ok_s     = par_ok_r;
    byte_s       = byte_r;
    byte_valid_s = 1'b0;
    frame_err_s  = 1'b0;
    timeout_s    = (state_r != ST_IDLE) && !fall_s && (to_cnt_r == TW'(TIMEOUT_CYCLES - 1));
    if (state_r == ST_IDLE || fall_s || timeout_s) begin
      to_cnt_s = '0;
    end else begin
      to_cnt_s = to_cnt_r + TW'(1);
    end
    if (timeout_s) begin
      state_s     = ST_IDLE;
      frame_err_s = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_sync_r) begin
            state_s   = ST_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_s   = {data_sync_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_ok_s = sampled_par_ok_s;
          state_s  = ST_STOP;
        end
        ST_STOP: begin
          state_s = ST_IDLE;
          if (data_sync_r && par_ok_r) begin
            byte_valid_s = 1'b1;
            byte_s       = shift_r;
          end else begin
            frame_err_s = 1'b1;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Synchronizers (idle-high lines reset to 1) and frame registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r   <= 1'b1;
      clk_sync_r   <= 1'b1;
      clk_prev_r   <= 1'b1;
      data_meta_r  <= 1'b1;
      data_sync_r  <= 1'b1;
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shift_r      <= 8'h00;
      par_ok_r     <= 1'b0;
      to_cnt_r     <= '0;
      byte_r       <= 8'h00;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      clk_meta_r   <= ps2_clk;
      clk_sync_r   <= clk_meta_r;
      clk_prev_r   <= clk_sync_r;
      data_meta_r  <= ps2_data;
      data_sync_r  <= data_meta_r;
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shift_r      <= shift_s;
      par_ok_r     <= par_ok_s;
      to_cnt_r     <= to_cnt_s;
      byte_r       <= byte_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign rx_byte    = byte_r;
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard controller: frame receiver, E0/F0 prefix decode, key-event queue.
// Parity checking is enabled by defining PS2_PARITY_CHECK_EN.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  input  logic       ovf_clr,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]   rx_byte_s;
  logic         byte_valid_s, frame_err_s;
  logic         ext_pend_r, brk_pend_r, overflow_r;
  key_event_t   mem_r [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [AW:0]  count_r;
  logic         is_prefix_s, push_req_s, pop_s, full_s, push_ok_s, drop_s;
  key_event_t   head_s;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte_s),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s)
  );

  assign is_prefix_s = (rx_byte_s == PS2_EXT_PREFIX) || (rx_byte_s == PS2_BRK_PREFIX);
  assign push_req_s  = byte_valid_s && !is_prefix_s;
  assign pop_s       = (count_r != '0) && key_ready;
  assign full_s      = (count_r == (AW+1)'(FIFO_DEPTH));
  // A full queue still accepts a push when the head is leaving the same cycle.
  assign push_ok_s   = push_req_s && (!full_s || pop_s);
  assign drop_s      = push_req_s && full_s && !pop_s;
  assign head_s      = mem_r[rd_ptr_r];

  // Prefix flags, queue storage/pointers and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_pend_r <= 1'b0;
      brk_pend_r <= 1'b0;
      overflow_r <= 1'b0;
      rd_ptr_r   <= '0;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (frame_err_s) begin
        ext_pend_r <= 1'b0;
        brk_pend_r <= 1'b0;
      end else if (byte_valid_s) begin
        if (rx_byte_s == PS2_EXT_PREFIX) begin
          ext_pend_r <= 1'b1;
        end else if (rx_byte_s == PS2_BRK_PREFIX) begin
          brk_pend_r <= 1'b1;
        end else begin
          ext_pend_r <= 1'b0;
          brk_pend_r <= 1'b0;
        end
      end
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= '{ext: ext_pend_r, brk: brk_pend_r, code: rx_byte_s};
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Head-of-queue presentation, zeroed when the queue is empty.
  always_comb begin
    key_valid = (count_r != '0);
    if (key_valid) begin
      key_code  = head_s.code;
      key_break = head_s.brk;
      key_ext   = head_s.ext;
    end else begin
      key_code  = 8'h00;
      key_break = 1'b0;
      key_ext   = 1'b0;
    end
  end

  assign frame_err = frame_err_s;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller with an expected-event scoreboard.
module tb_ps2_key_controller;

  localparam int HALF = 20;
  localparam int TO   = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       key_valid, key_break, key_ext, frame_err, overflow;
  logic [7:0] key_code;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ferr_base;
  logic [9:0] exp_q[$];

  ps2_key_controller #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_ready (key_ready),
    .ovf_clr   (ovf_clr),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_break (key_break),
    .key_ext   (key_ext),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err === 1'b1) ferr_cnt++;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic chk_lat);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    @(negedge clk) ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (chk_lat) begin
      repeat (3) @(posedge clk);
      #1 chk("lat_early", {15'd0, key_valid}, 16'd0);
      @(posedge clk);
      #1 chk("lat_rise", {15'd0, key_valid}, 16'd1);
    end
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop_check(input string tag);
    int n;
    logic [9:0] expv;
    n = 0;
    while (key_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, {15'd0, key_valid}, 16'd1);
    if (key_valid === 1'b1) begin
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
      chk(tag, {6'd0, key_ext, key_break, key_code}, {6'd0, expv});
      @(negedge clk) key_ready = 1'b1;
      @(posedge clk);
      #1 key_ready = 1'b0;
    end
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", {15'd0, key_valid}, 16'd0);
    chk("rst_code", {8'd0, key_code}, 16'd0);
    chk("rst_flags", {13'd0, key_break, key_ext, frame_err}, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // plain make code with exact latency
    ferr_base = ferr_cnt;
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b1);
    pop_check("make_1c");
    chk("make_no_ferr", 16'(ferr_cnt - ferr_base), 16'd0);

    // extended release
    exp_q.push_back({2'b11, 8'h75});
    send_frame(8'hE0, 1'b0, 1'b0);
    chk("prefix_e0_noevt", {15'd0, key_valid}, 16'd0);
    send_frame(8'hF0, 1'b0, 1'b0);
    chk("prefix_f0_noevt", {15'd0, key_valid}, 16'd0);
    send_frame(8'h75, 1'b0, 1'b0);
    pop_check("ext_brk_75");
    repeat (2) @(negedge clk);
    chk("ext_brk_single", {15'd0, key_valid}, 16'd0);

    // overflow: five events into a four-entry queue
    exp_q.push_back({2'b00, 8'h15});
    exp_q.push_back({2'b00, 8'h1D});
    exp_q.push_back({2'b00, 8'h24});
    exp_q.push_back({2'b00, 8'h2D});
    send_frame(8'h15, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'h24, 1'b0, 1'b0);
    chk("ovf_not_yet", {15'd0, overflow}, 16'd0);
    send_frame(8'h2D, 1'b0, 1'b0);
    send_frame(8'h2C, 1'b0, 1'b0);
    chk("ovf_set", {15'd0, overflow}, 16'd1);
    for (int i = 0; i < 4; i++) pop_check("ovf_pop");
    repeat (2) @(negedge clk);
    chk("ovf_empty", {15'd0, key_valid}, 16'd0);
    chk("empty_code_zero", {8'd0, key_code}, 16'd0);
    chk("ovf_sticky", {15'd0, overflow}, 16'd1);
    @(negedge clk) ovf_clr = 1'b1;
    @(negedge clk) ovf_clr = 1'b0;
    chk("ovf_cleared", {15'd0, overflow}, 16'd0);

    // bad parity on 0x1C
    ferr_base = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
`ifdef PS2_PARITY_CHECK_EN
    chk("par_ferr", 16'(ferr_cnt - ferr_base), 16'd1);
    chk("par_noevt", {15'd0, key_valid}, 16'd0);
`else
    chk("par_ignored_ferr", 16'(ferr_cnt - ferr_base), 16'd0);
    exp_q.push_back({2'b00, 8'h1C});
    pop_check("par_ignored_evt");
`endif

    // stalled frame times out, next frame recovers
    ferr_base = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    repeat (TO + 50) @(negedge clk);
    chk("timeout_ferr", 16'(ferr_cnt - ferr_base), 16'd1);
    chk("timeout_noevt", {15'd0, key_valid}, 16'd0);
    exp_q.push_back({2'b00, 8'h29});
    send_frame(8'h29, 1'b0, 1'b0);
    pop_check("after_timeout_29");

    // reset mid-frame with a queued event and pending E0
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    chk("pre_rst_valid", {15'd0, key_valid}, 16'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_valid", {15'd0, key_valid}, 16'd0);
    chk("midrst_outs", {5'd0, key_break, key_ext, frame_err, overflow, key_code[6:0]}, 16'd0);
    exp_q.delete();
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back({2'b00, 8'h1C});
    send_frame(8'h1C, 1'b0, 1'b0);
    pop_check("post_rst_1c");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_controller.md
PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-event queue depth (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle clk cycles mid-frame before abort.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port key_ready  input  1  consumer accepts the head event this cycle.
REQ-008 SHALL have port ovf_clr  input  1  clears the overflow flag.
REQ-009 SHALL have port key_valid  output  1  queue non-empty; head event presented.
REQ-010 SHALL have port key_code  output  8  head scan code.
REQ-011 SHALL have port key_break  output  1  head event is a release (F0-prefixed).
REQ-012 SHALL have port key_ext  output  1  head event is extended (E0-prefixed).
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse per rejected frame.
REQ-014 SHALL have port overflow  output  1  sticky: an event was dropped on a full queue.

Function
REQ-015 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers and detect a falling edge as synced-previous=1, synced-current=0.
REQ-016 SHALL run frame FSM IDLE->DATA->PARITY->STOP->IDLE, advancing only on detected falling edges.
REQ-017 IDLE SHALL move to DATA only when synced data=0 (start bit); data=1 stays IDLE.
REQ-018 DATA SHALL shift 8 bits LSB-first using a 3-bit counter, then go to PARITY; PARITY captures the bit and goes to STOP.
REQ-019 STOP SHALL accept the byte when data=1 (and parity passes per REQ-031), else pulse frame_err; both return to IDLE.
REQ-020 Outside IDLE, a counter reset on every falling edge SHALL abort to IDLE with a frame_err pulse on reaching TIMEOUT_CYCLES-1.
REQ-021 Accepted byte E0 SHALL set ext_pend; F0 SHALL set brk_pend; neither is queued.
REQ-022 Any other accepted byte SHALL push {ext_pend, brk_pend, byte} and clear both flags in the same cycle.
REQ-023 A frame_err pulse SHALL clear ext_pend and brk_pend.
REQ-024 key_valid SHALL rise exactly 2 clk cycles after the cycle the stop-bit falling edge is detected, when the queue was empty.
REQ-025 Pop SHALL occur on the rising edge where key_valid and key_ready are both 1; outputs show the next entry the following cycle.
REQ-026 Push on full queue without simultaneous pop SHALL drop the new event and set overflow; push with pop on full SHALL succeed.
REQ-027 overflow SHALL stay set until ovf_clr=1; simultaneous ovf_clr and new drop SHALL leave overflow=1.
REQ-028 key_code/key_break/key_ext SHALL be 0 while key_valid=0.

Reset
REQ-029 rst_n=0 SHALL immediately force FSM IDLE, queue empty, flags/counters 0, synchronizer flops 1, all outputs 0.
REQ-030 Reset mid-frame SHALL discard the partial byte; first frame after release is received normally from its start bit.

Configuration
REQ-031 With PS2_PARITY_CHECK_EN defined, byte XOR-reduced with parity bit SHALL equal 1 (odd) or the frame is rejected with frame_err; undefined, the parity bit SHALL be sampled and ignored.

Structure
REQ-032 Package ps2_pkg SHALL hold the frame-state enum, constants PS2_EXT_PREFIX=8'hE0 and PS2_BRK_PREFIX=8'hF0, and the 10-bit key-event type.
REQ-033 Synchronizers, frame FSM and timeout SHALL live in sub-module ps2_rx_frame, outputting a byte plus one-cycle byte_valid and frame_err.

Verification
REQ-034 Frame 0x1C, odd parity 0, stop 1 -> key_valid=1, key_code=0x1C, key_break=0, key_ext=0, frame_err never pulses.
REQ-035 Frames E0, F0, 0x75 -> single event key_code=0x75, key_ext=1, key_break=1; no event for prefixes.
REQ-036 Five events, key_ready=0, FIFO_DEPTH=4 -> four queued, overflow=1; pop all in order; ovf_clr -> overflow=0.
REQ-037 Parity bit inverted on 0x1C -> frame_err pulse, no event with PS2_PARITY_CHECK_EN; event 0x1C without.
REQ-038 Stop after 4 data bits beyond TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next full 0x29 frame -> event 0x29.
REQ-039 rst_n low mid-frame, pending E0 -> outputs 0; subsequent 0x1C frame -> key_ext=0.
